// File: rtl/mips_instr_encoder.sv
// Encodes MIPS instruction fields from a valid/ready stream into imem words.
// Define MIPS_ENC_DELAY_SLOT_EN to append a nop after every branch/jump word.
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              full,
    output logic              err
);

`ifdef MIPS_ENC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] AMAX  = '1;
    localparam logic [ADDR_W-1:0] AONE  = 1;
    localparam logic [ADDR_W:0]   CONE  = 1;

    typedef enum logic [2:0] {
        IDLE, WRITE, SLOT, DONE, FULL, ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       word;
    logic              last_r;
    logic              br_r;

    logic [31:0] enc_word;
    logic        enc_ok;
    logic        is_br;

    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        is_br    = 1'b0;
        case (kind)
            4'd0: enc_word = {6'b000000, rs, rt, rd, shamt, funct};
            4'd1: enc_word = {6'b100011, rs, rt, imm};
            4'd2: enc_word = {6'b101011, rs, rt, imm};
            4'd3: begin
                enc_word = {6'b000100, rs, rt, imm};
                is_br    = 1'b1;
            end
            4'd4: enc_word = {6'b001000, rs, rt, imm};
            4'd5: begin
                enc_word = {6'b000010, target};
                is_br    = 1'b1;
            end
            4'd6: enc_word = {6'b001111, 5'd0, rt, imm};
            4'd7: enc_word = {6'b001010, rs, rt, imm};
            4'd8: begin
                enc_word = {6'b000110, rs, 5'd0, imm};
                is_br    = 1'b1;
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state  <= IDLE;
            addr   <= '0;
            count  <= '0;
            done   <= 1'b0;
            full   <= 1'b0;
            err    <= 1'b0;
            word   <= '0;
            last_r <= 1'b0;
            br_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (enc_ok) begin
                            word   <= enc_word;
                            last_r <= in_last;
                            br_r   <= is_br;
                            state  <= WRITE;
                        end else begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                WRITE, SLOT: begin
                    count <= count + CONE;
                    // Address saturates at the top word; no wrap.
                    if (addr != AMAX)
                        addr <= addr + AONE;
                    else
                        full <= 1'b1;
                    if (DS && state == WRITE && br_r && addr != AMAX) begin
                        word  <= '0;
                        state <= SLOT;
                    end else if (last_r) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (addr == AMAX) begin
                        state <= FULL;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign imem_we   = (state == WRITE || state == SLOT) && !reset && !clear;
    assign imem_addr = addr;
    assign imem_wd   = word;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder against a field-level model.
// Covers both ADDR_W=6 and a tiny ADDR_W=2 instance for the full case.
module tb_mips_instr_encoder;

    localparam int AW  = 6;
    localparam int AW2 = 2;

`ifdef MIPS_ENC_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [3:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic          in_ready, imem_we, done, full, err;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wd;
    logic [AW:0]   count;

    logic           in_ready2, imem_we2, done2, full2, err2;
    logic [AW2-1:0] imem_addr2;
    logic [31:0]    imem_wd2;
    logic [AW2:0]   count2;

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .count(count), .done(done), .full(full), .err(err)
    );

    mips_instr_encoder #(.ADDR_W(AW2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm(imm), .target(target),
        .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wd(imem_wd2),
        .count(count2), .done(done2), .full(full2), .err(err2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [AW-1:0]  qa[$];
    logic [31:0]    qw[$];
    logic [AW2-1:0] qa2[$];
    logic [31:0]    exp_q[$];

    always @(negedge clk) begin
        if (imem_we) begin
            qa.push_back(imem_addr);
            qw.push_back(imem_wd);
        end
        if (imem_we2) qa2.push_back(imem_addr2);
    end

    function automatic logic [31:0] ref_enc(input int k, input int s,
        input int t, input int d, input int sh, input int fn,
        input int im, input int tg);
        int op[9] = '{0, 35, 43, 4, 8, 2, 15, 10, 6};
        longint w;
        int ss, tt;
        if (k == 0) begin
            w = longint'(s) * 2097152 + longint'(t) * 65536
              + longint'(d) * 2048 + longint'(sh) * 64 + fn;
        end else if (k == 5) begin
            w = longint'(op[k]) * 67108864 + tg;
        end else begin
            ss = (k == 6) ? 0 : s;
            tt = (k == 8) ? 0 : t;
            w = longint'(op[k]) * 67108864 + longint'(ss) * 2097152
              + longint'(tt) * 65536 + im;
        end
        return w[31:0];
    endfunction

    function automatic bit is_br(input int k);
        return k == 3 || k == 5 || k == 8;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        qa.delete();
        qw.delete();
        qa2.delete();
        exp_q.delete();
    endtask

    // Drives fields and queues the expected word(s) for the main instance.
    task automatic set_fields(input int k, input int s, input int t,
        input int d, input int sh, input int fn, input int im,
        input int tg, input bit last);
        kind = 4'(k); rs = 5'(s); rt = 5'(t); rd = 5'(d);
        shamt = 5'(sh); funct = 6'(fn); imm = 16'(im);
        target = 26'(tg); in_last = last;
        if (k <= 8) begin
            exp_q.push_back(ref_enc(k, s, t, d, sh, fn, im, tg));
            if (DS && is_br(k)) exp_q.push_back(32'h0);
        end
    endtask

    task automatic send(input int which, input int bound, output bit ok);
        int n = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        while (n < bound) begin
            if ((which == 0) ? in_ready : in_ready2) begin
                tick;
                ok = 1'b1;
                break;
            end
            tick;
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (!done && n < bound) begin
            tick;
            n++;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL done_timeout: done=%b required 1", done);
        end
    endtask

    task automatic check_image(input string nm);
        logic [AW:0] ecnt;
        ecnt = (AW+1)'(exp_q.size());
        total++;
        if (qw.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_len: got %0d required %0d",
                     nm, qw.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < qw.size(); i++) begin
            total++;
            if (qw[i] !== exp_q[i] || qa[i] !== AW'(i)) begin
                bad++;
                $display("FAIL %s_word%0d: got @%0d %h required @%0d %h",
                         nm, i, qa[i], qw[i], i, exp_q[i]);
            end
        end
        total++;
        if (count !== ecnt) begin
            bad++;
            $display("FAIL %s_count: got %0d required %0d", nm, count, ecnt);
        end
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        total++;
        if ({in_ready, imem_we, done, full, err} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags: got %b required 10000",
                     {in_ready, imem_we, done, full, err});
        end
        total++;
        if (count !== '0 || imem_addr !== '0 || imem_wd !== '0) begin
            bad++;
            $display("FAIL reset_regs: got cnt=%0d a=%0d wd=%h required 0",
                     count, imem_addr, imem_wd);
        end
    endtask

    task automatic test_addi;
        bit ok;
        do_reset;
        set_fields(4, 0, 8, 0, 0, 0, 16'h0005, 0, 1'b0);
        send(0, 20, ok);
        @(negedge clk);
        total++;
        if (!ok || imem_we !== 1'b1 || imem_addr !== '0
            || imem_wd !== exp_q[0]) begin
            bad++;
            $display("FAIL addi_write: got ok=%b we=%b a=%0d wd=%h required we=1 a=0 wd=%h",
                     ok, imem_we, imem_addr, imem_wd, exp_q[0]);
        end
        tick;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || count !== 7'd1 || imem_we !== 1'b0) begin
            bad++;
            $display("FAIL addi_after: got rdy=%b cnt=%0d we=%b required 1 1 0",
                     in_ready, count, imem_we);
        end
    endtask

    task automatic test_rtype_lui;
        bit ok;
        do_reset;
        set_fields(0, 17, 18, 16, 0, 6'h20, 0, 0, 1'b0);
        send(0, 20, ok);
        set_fields(6, 5, 9, 0, 0, 0, 16'h1234, 0, 1'b0);
        send(0, 20, ok);
        tick;
        tick;
        check_image("rtype_lui");
    endtask

    task automatic test_branch_last;
        bit ok;
        do_reset;
        set_fields(8, 4, 7, 0, 0, 0, 16'hFFFE, 0, 1'b0);
        send(0, 20, ok);
        set_fields(5, 0, 0, 0, 0, 0, 0, 26'h0100008, 1'b1);
        send(0, 20, ok);
        wait_done(20);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL branch_done: got rdy=%b done=%b required 0 1",
                     in_ready, done);
        end
        check_image("branch");
    endtask

    task automatic test_illegal;
        bit ok;
        do_reset;
        set_fields(12, 1, 2, 3, 0, 0, 0, 0, 1'b0);
        send(0, 20, ok);
        @(negedge clk);
        total++;
        if (imem_we !== 1'b0 || err !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL illegal_err: got we=%b err=%b rdy=%b required 0 1 0",
                     imem_we, err, in_ready);
        end
        tick;
        tick;
        @(negedge clk);
        total++;
        if (qa.size() != 0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL illegal_hold: got writes=%0d rdy=%b required 0 0",
                     qa.size(), in_ready);
        end
        tick;
        clear = 1'b1;
        tick;
        clear = 1'b0;
        @(negedge clk);
        total++;
        if (err !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_err: got err=%b rdy=%b required 0 1",
                     err, in_ready);
        end
        tick;
        set_fields(4, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0, 0,
                   $urandom_range(0, 65535), 0, 1'b0);
        send(0, 20, ok);
        tick;
        check_image("after_clear");
    endtask

    task automatic test_clear_vs_valid;
        do_reset;
        set_fields(4, 1, 2, 0, 0, 0, 16'h00AA, 0, 1'b0);
        exp_q.delete();
        clear = 1'b1;
        in_valid = 1'b1;
        tick;
        clear = 1'b0;
        in_valid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        total++;
        if (qa.size() != 0 || count !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_wins: got writes=%0d cnt=%0d rdy=%b required 0 0 1",
                     qa.size(), count, in_ready);
        end
    endtask

    task automatic test_full;
        bit ok;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            set_fields(4, 0, $urandom_range(0, 31), 0, 0, 0, i, 0, 1'b0);
            send(1, 20, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL full_accept%0d: got ok=0 required 1", i);
            end
        end
        set_fields(4, 0, 1, 0, 0, 0, 99, 0, 1'b0);
        send(1, 10, ok);
        @(negedge clk);
        total++;
        if (ok || full2 !== 1'b1 || count2 !== 3'd4 || in_ready2 !== 1'b0) begin
            bad++;
            $display("FAIL full_state: got ok=%b full=%b cnt=%0d rdy=%b required 0 1 4 0",
                     ok, full2, count2, in_ready2);
        end
        total++;
        if (qa2.size() != 4) begin
            bad++;
            $display("FAIL full_writes: got %0d required 4", qa2.size());
        end
        for (int i = 0; i < 4 && i < qa2.size(); i++) begin
            total++;
            if (qa2[i] !== AW2'(i)) begin
                bad++;
                $display("FAIL full_addr%0d: got %0d required %0d",
                         i, qa2[i], i);
            end
        end
    endtask

    task automatic test_reset_in_write;
        bit ok;
        do_reset;
        set_fields(4, 3, 4, 0, 0, 0, 16'h0777, 0, 1'b0);
        send(0, 20, ok);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (!ok || imem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_write_we: got ok=%b we=%b required 1 0",
                     ok, imem_we);
        end
        tick;
        @(negedge clk);
        total++;
        if (count !== '0 || imem_addr !== '0 || imem_wd !== '0
            || {in_ready, done, full, err} !== 4'b1000 || qa.size() != 0) begin
            bad++;
            $display("FAIL rst_write_state: got cnt=%0d a=%0d wd=%h flags=%b writes=%0d required 0 0 0 1000 0",
                     count, imem_addr, imem_wd,
                     {in_ready, done, full, err}, qa.size());
        end
        tick;
        reset = 1'b0;
    endtask

    task automatic test_random;
        bit ok;
        int k;
        do_reset;
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, 8);
            set_fields(k, $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 63), $urandom_range(0, 65535),
                       $urandom_range(0, 26'h3FFFFFF), i == 19);
            send(0, 20, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL rand_accept%0d: got ok=0 required 1", i);
            end
        end
        wait_done(20);
        @(negedge clk);
        check_image("random");
    endtask

    initial begin
        test_reset;
        test_addi;
        test_rtype_lui;
        test_branch_last;
        test_illegal;
        test_clear_vs_valid;
        test_full;
        test_reset_in_write;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
- Inverse of the single-cycle MIPS main decoder: accepts instruction fields over a valid/ready stream and encodes them into 32-bit MIPS words.
- Writes the words sequentially into instruction memory, for testbench program loading and self-loading demos.
- Supports exactly the opcode set the main decoder recognises: RTYPE, LW, SW, BEQ, ADDI, J, LUI, SLTI, BLEZ.

Parameters:
- ADDR_W, 6, word-address width of imem port; capacity 2**ADDR_W words.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- clear  in  1  synchronous soft restart: addr/count/flags to 0, state IDLE
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder can accept
- in_last  in  1  marks final instruction of program
- kind  in  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 LUI, 7 SLTI, 8 BLEZ, 9-15 illegal
- rs, rt, rd, shamt  in  5 each  register/shift fields
- funct  in  6  R-type function
- imm  in  16  immediate/offset
- target  in  26  jump target
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  word address
- imem_wd  out  32  encoded word
- count  out  ADDR_W+1  words written since reset/clear
- done  out  1  sticky: last instruction written
- full  out  1  sticky: memory filled
- err  out  1  sticky: illegal kind received

Behaviour:
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010, LUI 001111, SLTI 001010, BLEZ 000110.
- Formats:
  - R: {op,rs,rt,rd,shamt,funct}.
  - I: {op,rs,rt,imm}.
  - J: {op,target}.
  - LUI forces rs=0. BLEZ forces rt=0.
  - Unused input fields are ignored.
- States: IDLE, WRITE, DONE, FULL, ERR.
- IDLE: in_ready=1. Handshake (in_valid & in_ready) registers the encoded word and in_last, then goes to WRITE. An illegal kind goes to ERR instead, err=1, and nothing is written.
- WRITE: one cycle. imem_we=1 with imem_addr=current addr and imem_wd=registered word. At the edge: addr+1, count+1. Next state:
  - DONE if registered last (done=1).
  - else FULL if addr was 2**ADDR_W-1 (full=1; no wrap, addr stays at max).
  - else IDLE.
- Throughput: 1 word per 2 cycles. in_ready=0 in WRITE, DONE, FULL, ERR.
- Precedence if last and full coincide: both done=1 and full=1 are set; state is DONE.
- DONE/FULL/ERR hold until clear or reset.
- clear with in_valid in the same cycle: clear wins, no accept.
- Reset values: state IDLE, addr 0, count 0, done/full/err 0, imem_wd 0, imem_we 0.
- imem_we = (state==WRITE) & ~reset & ~clear. A reset or clear in a WRITE cycle suppresses that write.
- Latency: handshake edge to imem_we high = 1 cycle.

Optional Feature:
- MIPS_ENC_DELAY_SLOT_EN defined:
  - After writing a BEQ, BLEZ or J word, the encoder enters state SLOT and writes 0x00000000 (nop) at the next address for one cycle before the normal next-state decision.
  - count includes the nop.
  - If the branch word hits the last address, FULL is taken and the nop is dropped.
  - in_last on a branch sets done after the nop.
- Undefined: no SLOT state; branches are written alone.

Test Plan:
- ADDI rs=0 rt=8 imm=0x0005 -> imem_we at addr 0, wd=0x20080005, count=1, in_ready back high 2 cycles after handshake.
- RTYPE rs=17 rt=18 rd=16 shamt=0 funct=0x20, then LUI rs=5 rt=9 imm=0x1234 -> addr0=0x02328020, addr1=0x3C091234 (rs forced 0).
- BLEZ rs=4 rt=7 imm=0xFFFE, then J target=0x0100008 with in_last=1 -> 0x1880FFFE, 0x08100008, done=1, in_ready=0. With DELAY_SLOT_EN: four words with 0x00000000 at addr1 and addr3, count=4.
- kind=12 -> no imem_we, err=1, in_ready stays 0. clear -> IDLE, err=0, next ADDI written at addr 0.
- ADDR_W=2, five back-to-back ADDIs -> four writes at addr 0..3, full=1, count=4, fifth never accepted.
- reset asserted during the WRITE cycle -> imem_we low that cycle, all outputs at reset values the next cycle.
